alu_operand_stage: RTL

//  Upstream/downstream neighbour of the 16-bit ALU: multi-cycle operand fetch, execute capture, writeback.

---
 rtl/alu_operand_stage_pkg.sv | 54 +++++
 rtl/regfile_8x16.sv | 31 +++
 rtl/alu_operand_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: widths, ALU op and shift
// encodings, FSM state encoding, the latched command record and the B shifter.
package alu_operand_stage_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  // Command fields captured at accept and held for the whole command.
  typedef struct packed {
    logic [AW-1:0] rn;
    logic [AW-1:0] rm;
    logic [AW-1:0] rd;
    logic [1:0]    op;
    logic [1:0]    shift;
    logic          asel;
    logic          bsel;
    logic [DW-1:0] imm;
    logic          wb;
    logic          setf;
  } cmd_t;

  // Single-position B-path shift; the bit shifted out is dropped.
  function automatic logic [DW-1:0] shift_b(input logic [DW-1:0] b,
                                            input logic [1:0]    sh);
    logic [DW-1:0] r;
    case (sh)
      SH_LSL1: r = {b[DW-2:0], 1'b0};
      SH_LSR1: r = {1'b0, b[DW-1:1]};
      SH_ASR1: r = {b[DW-1], b[DW-1:1]};
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// 8 x 16 register file: one synchronous write port, one combinational read
// port, synchronous reset clears every entry.
module regfile_8x16
  import alu_operand_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ridx,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [NREG];

  // Storage: clear on reset, otherwise apply the single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read is combinational so the owning state captures it at its own edge.
  always_comb begin
    rdata = mem[ridx];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch / execute capture / writeback stage around an external
// 16-bit ALU. One command in flight: IDLE -> RD_A -> RD_B -> EXEC -> WB.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high exactly while the FSM is IDLE,
// and the upstream may hold cmd_valid across busy cycles without effect.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_rn,
  input  logic [AW-1:0] cmd_rm,
  input  logic [AW-1:0] cmd_rd,
  input  logic [1:0]    cmd_op,
  input  logic [1:0]    cmd_shift,
  input  logic          cmd_asel,
  input  logic          cmd_bsel,
  input  logic [DW-1:0] cmd_imm,
  input  logic          cmd_wb,
  input  logic          cmd_setf,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_idx,
  input  logic [DW-1:0] ext_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_z,
  output logic [DW-1:0] c_out,
  output logic [2:0]    status,
  output logic          done,
  output state_t        dbg_state
);

  state_t        state, state_nxt;
  cmd_t          cmd_q;
  logic [DW-1:0] a_q, b_q, c_q;
  logic [2:0]    stat_q;
  logic          accept;
  logic          v_flag;

  logic          rf_we;
  logic [AW-1:0] rf_widx, rf_ridx;
  logic [DW-1:0] rf_wdata, rf_rdata;

  assign accept = cmd_valid && (state == S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: fixed sequence, only IDLE waits for an accepted command.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RD_A;
      S_RD_A:  state_nxt = S_RD_B;
      S_RD_B:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    done      = (state == S_WB);
    dbg_state = state;
  end

  // Command latch: fields are frozen from accept until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q <= '0;
    end else if (accept) begin
      cmd_q <= '{rn: cmd_rn, rm: cmd_rm, rd: cmd_rd, op: cmd_op,
                 shift: cmd_shift, asel: cmd_asel, bsel: cmd_bsel,
                 imm: cmd_imm, wb: cmd_wb, setf: cmd_setf};
    end
  end

  // Register file ports: external writes only in IDLE, writeback only in WB,
  // so the two sources never contend. Read index follows the fetch state.
  always_comb begin
    rf_we    = 1'b0;
    rf_widx  = ext_idx;
    rf_wdata = ext_data;
    if (state == S_IDLE && ext_we) begin
      rf_we = 1'b1;
    end else if (state == S_WB && cmd_q.wb) begin
      rf_we    = 1'b1;
      rf_widx  = cmd_q.rd;
      rf_wdata = c_q;
    end
    rf_ridx = (state == S_RD_B) ? cmd_q.rm : cmd_q.rn;
  end

  regfile_8x16 u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .widx  (rf_widx),
    .wdata (rf_wdata),
    .ridx  (rf_ridx),
    .rdata (rf_rdata)
  );

  // ALU drive from latched fields; only meaningful during EXEC.
  always_comb begin
    alu_a  = cmd_q.asel ? '0 : a_q;
    alu_b  = cmd_q.bsel ? cmd_q.imm : shift_b(b_q, cmd_q.shift);
    alu_op = cmd_q.op;
  end

  // Signed overflow from the operands actually presented to the ALU.
  always_comb begin
    v_flag = 1'b0;
    case (cmd_q.op)
      OP_ADD:  v_flag = (alu_a[DW-1] == alu_b[DW-1]) && (alu_out[DW-1] != alu_a[DW-1]);
      OP_SUB:  v_flag = (alu_a[DW-1] != alu_b[DW-1]) && (alu_out[DW-1] != alu_a[DW-1]);
      default: v_flag = 1'b0;
    endcase
  end

  // Operand fetch, result capture and optional {N,V,Z} update.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      stat_q <= '0;
    end else begin
      case (state)
        S_RD_A: a_q <= rf_rdata;
        S_RD_B: b_q <= rf_rdata;
        S_EXEC: begin
          c_q <= alu_out;
          if (cmd_q.setf) stat_q <= {alu_out[DW-1], v_flag, alu_z};
        end
        default: ;
      endcase
    end
  end

  assign c_out  = c_q;
  assign status = stat_q;

endmodule
